// File: rtl/sad_min_find.sv
// Scans N_BLOCKS SAD words from the C memory and reports the smallest one,
// its address, and whether it falls within a threshold latched at Go.
module sad_min_find #(
    parameter int AC_WIDTH = 7,
    parameter int D_WIDTH  = 32,
    parameter int N_BLOCKS = 128
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Go,
    input  logic [D_WIDTH-1:0]  Threshold,
    output logic [AC_WIDTH-1:0] C_Addr,
    output logic                C_RW,
    output logic                C_En,
    input  logic [D_WIDTH-1:0]  C_Data,
    output logic                Busy,
    output logic                Done,
    output logic [D_WIDTH-1:0]  Min_SAD,
    output logic [AC_WIDTH-1:0] Min_Idx,
    output logic                Match
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_REQ  = 3'd2,
        S_WAIT = 3'd3,
        S_CMP  = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    localparam logic [AC_WIDTH-1:0] LAST_IDX = AC_WIDTH'(N_BLOCKS - 1);

    state_t              state_q, state_d;
    logic [AC_WIDTH-1:0] cnt_q, cnt_d;
    logic                first_q, first_d;
    logic [D_WIDTH-1:0]  run_min_q, run_min_d;
    logic [AC_WIDTH-1:0] run_idx_q, run_idx_d;
    logic [D_WIDTH-1:0]  thr_q, thr_d;
    logic [AC_WIDTH-1:0] c_addr_q, c_addr_d;
    logic                c_en_q, c_en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [D_WIDTH-1:0]  min_sad_q, min_sad_d;
    logic [AC_WIDTH-1:0] min_idx_q, min_idx_d;
    logic                match_q, match_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        run_min_d = run_min_q;
        run_idx_d = run_idx_q;
        thr_d     = thr_q;
        c_addr_d  = '0;
        c_en_d    = 1'b0;
        done_d    = 1'b0;
        min_sad_d = min_sad_q;
        min_idx_d = min_idx_q;
        match_d   = match_q;

        case (state_q)
            S_IDLE: begin
                if (Go) begin
                    thr_d   = Threshold;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                cnt_d   = '0;
                first_d = 1'b1;
                state_d = S_REQ;
            end
            S_REQ: begin
                c_addr_d = cnt_q;
                c_en_d   = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                state_d = S_CMP;
            end
            S_CMP: begin
                // First entry is always taken so an all-ones word can win.
                if (first_q || (C_Data < run_min_q)) begin
                    run_min_d = C_Data;
                    run_idx_d = cnt_q;
                end
                first_d = 1'b0;
                if (cnt_q == LAST_IDX) begin
                    state_d = S_FIN;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_REQ;
                end
            end
            S_FIN: begin
                min_sad_d = run_min_q;
                min_idx_d = run_idx_q;
                match_d   = (run_min_q <= thr_q);
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            first_q   <= 1'b0;
            run_min_q <= '0;
            run_idx_q <= '0;
            thr_q     <= '0;
            c_addr_q  <= '0;
            c_en_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            min_sad_q <= '0;
            min_idx_q <= '0;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            first_q   <= first_d;
            run_min_q <= run_min_d;
            run_idx_q <= run_idx_d;
            thr_q     <= thr_d;
            c_addr_q  <= c_addr_d;
            c_en_q    <= c_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            min_sad_q <= min_sad_d;
            min_idx_q <= min_idx_d;
            match_q   <= match_d;
        end
    end

    assign C_Addr  = c_addr_q;
    assign C_RW    = 1'b0;
    assign C_En    = c_en_q;
    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Min_SAD = min_sad_q;
    assign Min_Idx = min_idx_q;
    assign Match   = match_q;

endmodule

// File: tb/tb_sad_min_find.sv
// Bench for sad_min_find with N_BLOCKS=4: directed scans against a 1-cycle
// synchronous-read memory model, results checked through expected queues.
module tb_sad_min_find;
    localparam int AW = 7;
    localparam int DW = 32;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          go = 1'b0;
    logic [DW-1:0] threshold = '0;
    logic [AW-1:0] c_addr;
    logic          c_rw;
    logic          c_en;
    logic [DW-1:0] c_data;
    logic          busy, done, match;
    logic [DW-1:0] min_sad;
    logic [AW-1:0] min_idx;

    sad_min_find #(.AC_WIDTH(AW), .D_WIDTH(DW), .N_BLOCKS(NB)) dut (
        .Clk(clk), .Rst(rst), .Go(go), .Threshold(threshold),
        .C_Addr(c_addr), .C_RW(c_rw), .C_En(c_en), .C_Data(c_data),
        .Busy(busy), .Done(done), .Min_SAD(min_sad), .Min_Idx(min_idx),
        .Match(match)
    );

    // clock / edge counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // memory model: read registered on the edge where C_En is high
    logic [DW-1:0] mem [NB];
    logic [DW-1:0] rd_q = '0;
    always @(posedge clk) if (c_en) rd_q <= mem[c_addr];
    assign c_data = rd_q;

    // scoreboard state
    logic [DW+AW+1+31:0] exp_q [$];   // {edge, sad, idx, match}
    logic [AW+31:0]      addr_q [$];  // {edge, addr}
    logic [DW-1:0] cur_sad = '0;
    logic [AW-1:0] cur_idx = '0;
    logic          cur_match = 1'b0;
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, cyc);
        end
    endtask

    // monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    logic [DW+AW+1+31:0] e;
                    e = exp_q.pop_front();
                    check("done_edge", 64'(cyc), 64'(e[DW+AW+1+31 -: 32]));
                    check("min_sad", 64'(min_sad), 64'(e[DW+AW -: DW]));
                    check("min_idx", 64'(min_idx), 64'(e[AW:1]));
                    check("match", 64'(match), 64'(e[0]));
                    check("busy_at_done", 64'(busy), 64'd0);
                    cur_sad   = e[DW+AW -: DW];
                    cur_idx   = e[AW:1];
                    cur_match = e[0];
                end
            end else begin
                check("results_hold", {31'd0, min_sad, min_idx, match},
                      {31'd0, cur_sad, cur_idx, cur_match});
            end
            if (c_en) begin
                if (addr_q.size() == 0) begin
                    check("unexpected_c_en", 64'd1, 64'd0);
                end else begin
                    logic [AW+31:0] a;
                    a = addr_q.pop_front();
                    check("c_en_edge", 64'(cyc), 64'(a[AW+31 -: 32]));
                    check("c_addr", 64'(c_addr), 64'(a[AW-1:0]));
                end
            end else begin
                check("c_addr_idle", 64'(c_addr), 64'd0);
            end
            check("c_rw", 64'(c_rw), 64'd0);
        end
    end

    // driver: issue Go at the next edge and queue everything it should produce
    task automatic push_scan(input int start, input logic [DW-1:0] s,
                             input logic [AW-1:0] idx, input logic m);
        exp_q.push_back({32'(start + 3*NB + 2), s, idx, m});
        for (int k = 0; k < NB; k++) addr_q.push_back({32'(start + 2 + 3*k), AW'(k)});
    endtask

    task automatic load_mem(input logic [DW-1:0] m0, input logic [DW-1:0] m1,
                            input logic [DW-1:0] m2, input logic [DW-1:0] m3);
        mem[0] = m0; mem[1] = m1; mem[2] = m2; mem[3] = m3;
    endtask

    task automatic start_scan(input logic [DW-1:0] th, input logic [DW-1:0] s,
                              input logic [AW-1:0] idx, input logic m, output int start);
        @(negedge clk);
        go = 1'b1;
        threshold = th;
        start = cyc + 1;
        push_scan(start, s, idx, m);
        @(negedge clk);
        go = 1'b0;
        threshold = $urandom_range(0, 1000);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("drain_timeout", 64'd1, 64'd0);
        @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_outputs"}, {c_addr, c_rw, c_en, busy, done, min_sad, min_idx, match},
              '0);
    endtask

    initial begin
        int st;
        load_mem(0, 0, 0, 0);
        #12;
        check_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // basic scan
        load_mem(40, 12, 99, 30);
        start_scan(15, 12, 1, 1'b1, st);
        wait_drain();

        // ties and extremes
        load_mem(32'hFFFF_FFFF, 32'hFFFF_FFFF, 7, 7);
        start_scan(6, 7, 2, 1'b0, st);
        wait_drain();

        // all ones, Go held high for two back-to-back scans
        load_mem(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        go = 1'b1;
        threshold = 32'hFFFF_FFFF;
        st = cyc + 1;
        push_scan(st, 32'hFFFF_FFFF, 0, 1'b1);
        push_scan(st + 15, 32'hFFFF_FFFF, 0, 1'b1);
        while (cyc < st + 29) @(negedge clk);
        go = 1'b0;
        wait_drain();

        // Go re-pulsed mid-scan is ignored
        load_mem(40, 12, 99, 30);
        start_scan(11, 12, 1, 1'b0, st);
        while (cyc < st + 5) @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_drain();

        // reset mid-scan, then a fresh scan
        load_mem(5, 3, 8, 1);
        start_scan(1, 1, 3, 1'b1, st);
        while (cyc < st + 7) @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        addr_q.delete();
        cur_sad = '0;
        cur_idx = '0;
        cur_match = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        @(negedge clk);
        rst = 1'b0;
        start_scan(1, 1, 3, 1'b1, st);
        wait_drain();

        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        check("addr_q_empty", 64'(addr_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
